// File: rtl/onehot_scan_decoder_if.sv
// Interface bundle between sequencing control and the one-hot scan decoder.
// SEL_W is derived from NOUT and is not meant to be overridden.
interface onehot_scan_decoder_if #(
    parameter int NOUT  = 32,
    parameter int SEL_W = $clog2(NOUT)
);
    logic             en;
    logic             load;
    logic             mode;
    logic             up;
    logic             blank;
    logic [SEL_W-1:0] Bin;
    logic [NOUT-1:0]  Bout;
    logic [SEL_W-1:0] Bidx;
    logic             wrap;
    logic             err;

    modport master (
        output en, load, mode, up, blank, Bin,
        input  Bout, Bidx, wrap, err
    );

    modport slave (
        input  en, load, mode, up, blank, Bin,
        output Bout, Bidx, wrap, err
    );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a prescaled up/down scan mode for
// multiplexed display digit / keypad row selection.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   S_IDLE | no line active; only a valid load leaves here
//   S_HOLD | static one-hot at the latched index
//   S_SCAN | index steps every SCAN_DIV enabled cycles
module onehot_scan_decoder #(
    parameter int NOUT     = 32,
    parameter int SCAN_DIV = 4
) (
    input logic                  clk,
    input logic                  rst,
    onehot_scan_decoder_if.slave bus
);
    localparam int SEL_W = $clog2(NOUT);
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SEL_W:0]   NOUT_V  = (SEL_W + 1)'(NOUT);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(NOUT - 1);
    localparam logic [PW-1:0]    PDIV_M1 = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [NOUT-1:0]  bout_q, bout_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            presc_q <= '0;
            bout_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            bout_q  <= bout_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        err_d   = err_q;

        if (bus.load) begin
            presc_d = '0;
            if ({1'b0, bus.Bin} < NOUT_V) begin
                idx_d   = bus.Bin;
                err_d   = 1'b0;
                state_d = bus.mode ? S_SCAN : S_HOLD;
            end else begin
                idx_d   = '0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (bus.mode) begin
                        state_d = S_SCAN;
                        presc_d = '0;
                    end
                end
                S_SCAN: begin
                    if (!bus.mode) begin
                        state_d = S_HOLD;
                        presc_d = '0;
                    end else if (bus.en) begin
                        if (presc_q == PDIV_M1) begin
                            presc_d = '0;
                            if (bus.up) begin
                                if (idx_q == LAST) begin
                                    idx_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    idx_d  = LAST;
                                    wrap_d = 1'b1;
                                end else begin
                                    idx_d = idx_q - 1'b1;
                                end
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Loop compare keeps non-power-of-two NOUT free of out-of-range selects
        bout_d = '0;
        for (int i = 0; i < NOUT; i++) begin
            bout_d[i] = (state_d != S_IDLE) && !bus.blank && (idx_d == SEL_W'(i));
        end
    end

    assign bus.Bout = bout_q;
    assign bus.Bidx = idx_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;
endmodule
